// File: rtl/play_record_store_pkg.sv
// play_record_store_pkg
//   Shared definitions for the play-record store: command opcodes,
//   response status codes and the default parameter values used by the
//   interface and the store itself.
package play_record_store_pkg;

   typedef enum logic [1:0] {
      OP_READ   = 2'd0,
      OP_APPEND = 2'd1,
      OP_DELETE = 2'd2,
      OP_BEST   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_EMPTY     = 2'd1,
      ST_FULL      = 2'd2,
      ST_NOT_FOUND = 2'd3
   } status_e;

   localparam int DEF_DEPTH      = 16;
   localparam int DEF_USER_W     = 8;
   localparam int DEF_NAME_CHARS = 16;
   localparam int DEF_SCORE_W    = 16;

endpackage

// File: rtl/play_record_store_if.sv
// play_record_store_if
//   Command/response bus between the menu/game FSM (master) and the
//   play-record store (slave), plus the store's occupancy status.
//   cmd_*      : command request (valid/ready handshake)
//   rsp_*      : response (valid/ready handshake)
//   count/full/empty : occupancy, driven by the store
interface play_record_store_if import play_record_store_pkg::*; #(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int USER_W     = DEF_USER_W,
   parameter int NAME_CHARS = DEF_NAME_CHARS,
   parameter int SCORE_W    = DEF_SCORE_W
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int REC_W = USER_W + 8*NAME_CHARS + SCORE_W;

   logic             cmd_valid;
   logic             cmd_ready;
   op_e              cmd_op;
   logic [IDX_W-1:0] cmd_idx;
   logic [REC_W-1:0] cmd_rec;

   logic             rsp_valid;
   logic             rsp_ready;
   status_e          rsp_status;
   logic [IDX_W-1:0] rsp_idx;
   logic [REC_W-1:0] rsp_rec;

   logic [IDX_W:0]   count;
   logic             full;
   logic             empty;

   modport master (
      output cmd_valid, cmd_op, cmd_idx, cmd_rec, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_status, rsp_idx, rsp_rec, count, full, empty
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_idx, cmd_rec, rsp_ready,
      output cmd_ready, rsp_valid, rsp_status, rsp_idx, rsp_rec, count, full, empty
   );

endinterface

// File: rtl/free_slot_finder.sv
// free_slot_finder
//   Combinational priority encoder: lowest-index clear bit of the slot
//   valid vector.
//   valid    in  DEPTH  per-slot valid bits
//   free_idx out IDX_W  lowest free slot (0 when none free)
//   any_free out 1      at least one slot is free
module free_slot_finder #(
   parameter  int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] valid,
   output logic [IDX_W-1:0] free_idx,
   output logic             any_free
);

   // Walk downwards so the last hit written is the lowest free index.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_idx = IDX_W'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/play_record_store.sv
// play_record_store
//   DEPTH-slot store of play records {user_id, chart_name, score} with a
//   valid bit per slot. Serves READ, APPEND (lowest free slot), DELETE and
//   BEST (highest score for a chart name, one slot per cycle).
//   clk       in  system clock
//   sys_rst_n in  asynchronous active-low reset
//   bus       slave side of play_record_store_if (command, response, occupancy)
module play_record_store import play_record_store_pkg::*; #(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int USER_W     = DEF_USER_W,
   parameter int NAME_CHARS = DEF_NAME_CHARS,
   parameter int SCORE_W    = DEF_SCORE_W
) (
   input logic               clk,
   input logic               sys_rst_n,
   play_record_store_if.slave bus
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int NAME_W = 8*NAME_CHARS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH-1);

   typedef struct packed {
      logic [USER_W-1:0]  user_id;
      logic [NAME_W-1:0]  chart_name;
      logic [SCORE_W-1:0] score;
   } rec_t;

   // Reset: asserts asynchronously, releases on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rst_sync <= '0;
      else            rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // Payload RAM is not reset; the valid bits alone define occupancy.
   rec_t             mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [IDX_W:0]   count;
   logic [1:0]       state;

   logic [IDX_W-1:0] ptr;
   logic [NAME_W-1:0] name_q;
   logic             best_found;
   logic [IDX_W-1:0] best_idx;
   logic [SCORE_W-1:0] best_score;

   status_e          st_q;
   logic [IDX_W-1:0] idx_q;
   rec_t             rec_q;

   logic [IDX_W-1:0] free_idx;
   logic             any_free;

   free_slot_finder #(.DEPTH(DEPTH)) u_free (
      .valid    (valid),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   rec_t cmd_rec, slot_rec, scan_rec;
   logic accept, in_range, slot_valid, hit;
   logic nxt_found;
   logic [IDX_W-1:0]   nxt_idx;
   logic [SCORE_W-1:0] nxt_score;

   assign cmd_rec    = bus.cmd_rec;
   assign accept     = bus.cmd_valid && (state == S_IDLE);
   assign in_range   = {1'b0, bus.cmd_idx} < DEPTH_C;
   assign slot_valid = in_range && valid[bus.cmd_idx];
   assign slot_rec   = mem[bus.cmd_idx];

   // Scan step: strict greater-than keeps the lowest index on ties.
   assign scan_rec  = mem[ptr];
   assign hit       = valid[ptr] && (scan_rec.chart_name == name_q) &&
                      (!best_found || (scan_rec.score > best_score));
   assign nxt_found = best_found | hit;
   assign nxt_idx   = hit ? ptr : best_idx;
   assign nxt_score = hit ? scan_rec.score : best_score;

   always_ff @(posedge clk) begin
      if (accept && (bus.cmd_op == OP_APPEND) && any_free)
         mem[free_idx] <= cmd_rec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         valid      <= '0;
         count      <= '0;
         st_q       <= ST_OK;
         idx_q      <= '0;
         rec_q      <= '0;
         ptr        <= '0;
         name_q     <= '0;
         best_found <= 1'b0;
         best_idx   <= '0;
         best_score <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               st_q  <= ST_OK;
               idx_q <= bus.cmd_idx;
               rec_q <= '0;
               state <= S_RESP;
               case (bus.cmd_op)
                  OP_READ: begin
                     if (slot_valid) rec_q <= slot_rec;
                     else            st_q  <= ST_EMPTY;
                  end
                  OP_APPEND: begin
                     if (any_free) begin
                        valid[free_idx] <= 1'b1;
                        count           <= count + 1'b1;
                        idx_q           <= free_idx;
                        rec_q           <= cmd_rec;
                     end else begin
                        st_q  <= ST_FULL;
                        idx_q <= '0;
                     end
                  end
                  OP_DELETE: begin
                     if (slot_valid) begin
                        valid[bus.cmd_idx] <= 1'b0;
                        count              <= count - 1'b1;
                        rec_q              <= slot_rec;
                     end else begin
                        st_q <= ST_EMPTY;
                     end
                  end
                  OP_BEST: begin
                     name_q     <= cmd_rec.chart_name;
                     ptr        <= '0;
                     best_found <= 1'b0;
                     best_idx   <= '0;
                     best_score <= '0;
                     state      <= S_SCAN;
                  end
                  default: ;
               endcase
            end
            S_SCAN: begin
               best_found <= nxt_found;
               best_idx   <= nxt_idx;
               best_score <= nxt_score;
               ptr        <= ptr + 1'b1;
               // Last slot folds straight into the response.
               if (ptr == LAST) begin
                  state <= S_RESP;
                  st_q  <= nxt_found ? ST_OK : ST_NOT_FOUND;
                  idx_q <= nxt_found ? nxt_idx : '0;
                  rec_q <= nxt_found ? mem[nxt_idx] : '0;
               end
            end
            S_RESP: if (bus.rsp_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = (state == S_IDLE);
   assign bus.rsp_valid  = (state == S_RESP);
   assign bus.rsp_status = st_q;
   assign bus.rsp_idx    = idx_q;
   assign bus.rsp_rec    = rec_q;
   assign bus.count      = count;
   assign bus.full       = (count == DEPTH_C);
   assign bus.empty      = (count == '0);

endmodule

// File: tb/tb_play_record_store.sv
// tb_play_record_store
//   Directed vector table for the play-record store plus hand-written
//   sequences for response hold and reset during a BEST scan.
module tb_play_record_store;
   import play_record_store_pkg::*;

   localparam logic [127:0] LS = "Little Stars    ";
   localparam logic [127:0] RB = "Ringing Bloom   ";
   localparam logic [127:0] FL = "Filler          ";
   localparam logic [127:0] UK = "Unknown         ";

   logic clk = 1'b0;
   logic sys_rst_n = 1'b1;
   always #5 clk = ~clk;

   play_record_store_if #(.DEPTH(16), .USER_W(8), .NAME_CHARS(16), .SCORE_W(16)) bus();

   play_record_store #(.DEPTH(16), .USER_W(8), .NAME_CHARS(16), .SCORE_W(16)) dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   typedef struct {
      op_e          op;
      logic [3:0]   idx;
      logic [151:0] rec;
      int           hold;
      status_e      st;
      logic [3:0]   ridx;
      logic [151:0] rrec;
      logic [4:0]   cnt;
      int           lat;
   } vec_t;

   vec_t tbl [64];
   int   nt;
   int   n_chk;
   int   n_bad;
   int   cur;

   function automatic logic [151:0] mk(input logic [7:0] u, input logic [127:0] n,
                                       input logic [15:0] s);
      return {u, n, s};
   endfunction

   function automatic logic [151:0] fill(input int k);
      case (k)
         2:       return mk(8'd2,  LS, 16'd4406);
         5:       return mk(8'd5,  LS, 16'd7000);
         9:       return mk(8'd9,  LS, 16'd7000);
         12:      return mk(8'd12, LS, 16'd6999);
         default: return mk(8'(k), FL, 16'(100 + k));
      endcase
   endfunction

   task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, cur, act, exp);
      end
   endtask

   task automatic add(input op_e op, input logic [3:0] idx, input logic [151:0] rec,
                      input status_e st, input logic [3:0] ridx, input logic [151:0] rrec,
                      input logic [4:0] cnt);
      tbl[nt] = '{op, idx, rec, 0, st, ridx, rrec, cnt, (op == OP_BEST) ? 17 : 1};
      nt++;
   endtask

   // One full command/response transaction checked against vector v.
   task automatic run(input vec_t v);
      int n;
      int lat;
      bus.rsp_ready = (v.hold == 0);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = v.op;
      bus.cmd_idx   = v.idx;
      bus.cmd_rec   = v.rec;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", 152'(bus.cmd_ready), 152'(1));
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_APPEND;
      bus.cmd_idx   = ~v.idx;
      bus.cmd_rec   = ~v.rec;
      lat = 1;
      while (!bus.rsp_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 152'(lat), 152'(v.lat));
      chk("status", 152'(bus.rsp_status), 152'(v.st));
      if (v.st != ST_EMPTY) chk("rsp_idx", 152'(bus.rsp_idx), 152'(v.ridx));
      chk("rsp_rec", bus.rsp_rec, v.rrec);
      chk("count", 152'(bus.count), 152'(v.cnt));
      chk("full", 152'(bus.full), 152'(v.cnt == 5'd16));
      chk("empty", 152'(bus.empty), 152'(v.cnt == 5'd0));
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 152'(bus.rsp_valid), 152'(1));
         chk("hold_status", 152'(bus.rsp_status), 152'(v.st));
         chk("hold_rec", bus.rsp_rec, v.rrec);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after", 152'(bus.cmd_ready), 152'(1));
      chk("valid_after", 152'(bus.rsp_valid), 152'(0));
   endtask

   task automatic chk_reset_outputs;
      chk("rst_cmd_ready", 152'(bus.cmd_ready), 152'(1));
      chk("rst_rsp_valid", 152'(bus.rsp_valid), 152'(0));
      chk("rst_status", 152'(bus.rsp_status), 152'(0));
      chk("rst_rsp_idx", 152'(bus.rsp_idx), 152'(0));
      chk("rst_rsp_rec", bus.rsp_rec, 152'(0));
      chk("rst_count", 152'(bus.count), 152'(0));
      chk("rst_empty", 152'(bus.empty), 152'(1));
      chk("rst_full", 152'(bus.full), 152'(0));
   endtask

   vec_t v;

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_READ;
      bus.cmd_idx   = '0;
      bus.cmd_rec   = '0;
      bus.rsp_ready = 1'b1;
      n_chk = 0;
      n_bad = 0;
      nt    = 0;
      cur   = -1;

      #3 sys_rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_reset_outputs();
      @(negedge clk);
      sys_rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      add(OP_READ, 4'd3, '0, ST_EMPTY, 4'd3, '0, 5'd0);
      tbl[0].hold = 5;
      add(OP_APPEND, 4'd0, mk(8'd2, LS, 16'd4406), ST_OK, 4'd0, mk(8'd2, LS, 16'd4406), 5'd1);
      add(OP_APPEND, 4'd0, mk(8'd1, RB, 16'd10940), ST_OK, 4'd1, mk(8'd1, RB, 16'd10940), 5'd2);
      add(OP_READ, 4'd1, '0, ST_OK, 4'd1, mk(8'd1, RB, 16'd10940), 5'd2);
      add(OP_DELETE, 4'd0, '0, ST_OK, 4'd0, mk(8'd2, LS, 16'd4406), 5'd1);
      add(OP_APPEND, 4'd0, mk(8'd3, LS, 16'd5000), ST_OK, 4'd0, mk(8'd3, LS, 16'd5000), 5'd2);
      add(OP_DELETE, 4'd0, '0, ST_OK, 4'd0, mk(8'd3, LS, 16'd5000), 5'd1);
      add(OP_DELETE, 4'd0, '0, ST_EMPTY, 4'd0, '0, 5'd1);
      add(OP_READ, 4'd0, '0, ST_EMPTY, 4'd0, '0, 5'd1);
      // Slot 1 stays occupied; appends land in 0, then 2..15.
      add(OP_APPEND, 4'd0, fill(0), ST_OK, 4'd0, fill(0), 5'd2);
      for (int k = 2; k < 16; k++)
         add(OP_APPEND, 4'd0, fill(k), ST_OK, 4'(k), fill(k), 5'(k + 1));
      add(OP_APPEND, 4'd0, mk(8'd7, LS, 16'd9999), ST_FULL, 4'd0, '0, 5'd16);
      add(OP_READ, 4'd5, '0, ST_OK, 4'd5, fill(5), 5'd16);
      add(OP_READ, 4'd15, '0, ST_OK, 4'd15, fill(15), 5'd16);
      add(OP_READ, 4'd1, '0, ST_OK, 4'd1, mk(8'd1, RB, 16'd10940), 5'd16);
      add(OP_BEST, 4'd0, mk(8'hFF, LS, 16'hFFFF), ST_OK, 4'd5, fill(5), 5'd16);
      add(OP_BEST, 4'd0, mk(8'd0, UK, 16'd0), ST_NOT_FOUND, 4'd0, '0, 5'd16);
      add(OP_DELETE, 4'd5, '0, ST_OK, 4'd5, fill(5), 5'd15);
      add(OP_BEST, 4'd0, mk(8'd0, LS, 16'd0), ST_OK, 4'd9, fill(9), 5'd15);
      add(OP_BEST, 4'd0, mk(8'd0, RB, 16'd0), ST_OK, 4'd1, mk(8'd1, RB, 16'd10940), 5'd15);

      for (int i = 0; i < nt; i++) begin
         cur = i;
         run(tbl[i]);
      end

      // Reset in the middle of a BEST scan.
      cur = 100;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_BEST;
      bus.cmd_rec   = mk(8'd0, LS, 16'd0);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("scan_cmd_ready", 152'(bus.cmd_ready), 152'(0));
      chk("scan_rsp_valid", 152'(bus.rsp_valid), 152'(0));
      sys_rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_count", 152'(bus.count), 152'(0));
      chk("post_rst_ready", 152'(bus.cmd_ready), 152'(1));

      cur = 101;
      v = '{OP_BEST, 4'd0, mk(8'd0, LS, 16'd0), 0, ST_NOT_FOUND, 4'd0, '0, 5'd0, 17};
      run(v);
      cur = 102;
      v = '{OP_READ, 4'd9, '0, 0, ST_EMPTY, 4'd9, '0, 5'd0, 1};
      run(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/play_record_store.md
Name: play_record_store

Overview:
- Parametrised successor to the fixed-size play-record storage.
- Holds up to DEPTH play records (user id, chart name, score), each with a per-slot valid bit.
- Serves READ, APPEND (auto-allocates a slot), DELETE and BEST (highest score for a chart name, found by a sequential scan).
- Single command/response handshake; sits between the menu/game FSM and the leaderboard display.

Parameters:
- DEPTH, 16: number of record slots (2..256, need not be a power of two).
- USER_W, 8: user id width in bits.
- NAME_CHARS, 16: chart name length in bytes (name width = 8*NAME_CHARS).
- SCORE_W, 16: unsigned score width in bits.

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=READ, 1=APPEND, 2=DELETE, 3=BEST
- cmd_idx  in  IDX_W=$clog2(DEPTH)  slot index for READ/DELETE
- cmd_rec  in  REC_W=USER_W+8*NAME_CHARS+SCORE_W  record for APPEND; only the name field is used for BEST
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_status  out  2  0=OK, 1=EMPTY, 2=FULL, 3=NOT_FOUND
- rsp_idx  out  IDX_W  slot involved
- rsp_rec  out  REC_W  record returned
- count  out  IDX_W+1  number of valid slots
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Reset (async assert, sync deassert internally):
  - All valid bits clear; count=0, empty=1, full=0.
  - rsp_valid=0, rsp_status=0, rsp_idx=0, rsp_rec=0.
  - FSM=IDLE, cmd_ready=1.
  - Record payload storage is not reset (RAM-mappable). There is no preload.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid&&cmd_ready.
    - READ/APPEND/DELETE -> RESP in the next cycle (1-cycle latency).
    - BEST -> SCAN.
  - SCAN: cmd_ready=0. Visits one slot per cycle, slots 0..DEPTH-1. After the last slot -> RESP. Latency from acceptance to rsp_valid is DEPTH+1 cycles.
  - RESP: rsp_valid=1, cmd_ready=0. Outputs stay stable until rsp_valid&&rsp_ready, then -> IDLE.
    - cmd_ready returns high the cycle after the handshake. There is no command/response overlap.
- READ:
  - Valid slot: status OK, rsp_rec=slot contents, rsp_idx=cmd_idx.
  - Invalid slot or cmd_idx>=DEPTH: status EMPTY, rsp_rec=0.
- APPEND:
  - Writes the lowest-index free slot, sets its valid bit, count+1. Response is status OK, rsp_idx=slot, rsp_rec=written record.
  - If full: no write, status FULL, rsp_idx=0, rsp_rec=0.
  - The write takes effect on the acceptance edge, so a later READ sees it.
- DELETE:
  - Valid slot: clears the valid bit, count-1, status OK, rsp_rec=old contents.
  - Invalid slot or out of range: status EMPTY, nothing changes.
- BEST:
  - cmd_rec name is latched at acceptance.
  - A slot matches when it is valid and its name equals the latched name exactly (all 8*NAME_CHARS bits).
  - Tracks the maximum score, unsigned, strict greater-than, so ties keep the lowest index.
  - Any match: status OK with that record and index. No match (including empty store): NOT_FOUND, rsp_rec=0.
- Count never underflows or overflows; full and empty are derived from count combinationally.
- Reset asserted mid-SCAN or mid-RESP aborts immediately to the reset state; no partial update survives.
- Inputs are ignored outside a handshake. cmd_op/cmd_idx/cmd_rec need not be held after acceptance.

Decomposition:
- Shared header package holds:
  - the cmd_op enum (OP_READ, OP_APPEND, OP_DELETE, OP_BEST);
  - the rsp_status enum (ST_OK, ST_EMPTY, ST_FULL, ST_NOT_FOUND);
  - default parameter constants.
- The record packing is defined as a module-local packed struct derived from the parameters, field order {user_id, chart_name, score}, MSB first.
- Sub-module free_slot_finder, parametrised by DEPTH: a combinational priority encoder over the valid vector, outputs free_idx and any_free.

Test Plan:
- Reset, then READ idx 3 -> status EMPTY, rsp_rec=0, count=0, empty=1; rsp_valid held while rsp_ready=0 for 5 cycles.
- APPEND {user 2, "Little Stars    ", 4406}, then {user 1, "Ringing Bloom   ", 10940} -> rsp_idx 0 then 1, count=2; READ 1 returns score 10940.
- DELETE 0, then APPEND {user 3, "Little Stars    ", 5000} -> reuses idx 0, count=2; second DELETE 0 after that -> OK; a third DELETE 0 -> EMPTY.
- Fill to DEPTH=16 -> full=1; 17th APPEND -> FULL, count stays 16, no slot changed.
- BEST "Little Stars    " with scores 4406@2, 7000@5, 7000@9 -> OK, idx 5, score 7000, rsp_valid exactly 17 cycles after acceptance; BEST "Unknown         " -> NOT_FOUND.
- Assert sys_rst_n low during SCAN cycle 4 -> all outputs at reset values at once; after release, count=0 and cmd_ready=1.
